// File: rtl/muxn_pipe.sv
// muxn_pipe: N-input W-bit registered selector with valid/ready handshake, flush and select-range flag.
// Optional MUXN_PIPE_SKID_EN adds a skid entry and a registered in_ready. Revision 1.0.
`default_nettype none

module muxn_pipe #(
   parameter int MUX_BIT_WIDTH = 8,
   parameter int NUM_INPUTS    = 4,
   parameter int SEL_WIDTH     = $clog2(NUM_INPUTS)
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [NUM_INPUTS*MUX_BIT_WIDTH-1:0] data_in,
   input  logic [SEL_WIDTH-1:0]                sel,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic                                flush,
   output logic [MUX_BIT_WIDTH-1:0]            data_out,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic                                sel_err
);

   // One extra bit so NUM_INPUTS itself is representable for the range compare.
   localparam logic [SEL_WIDTH:0] c_num_inputs = NUM_INPUTS[SEL_WIDTH:0];

   logic                     accept;
   logic                     transfer;
   logic [MUX_BIT_WIDTH-1:0] sel_data;
   logic                     sel_oor;

   logic                     main_valid_q, main_valid_d;
   logic [MUX_BIT_WIDTH-1:0] main_data_q, main_data_d;
   logic                     main_err_q, main_err_d;

   // Out-of-range selects fall through the loop and capture zero.
   always_comb begin
      sel_data = '0;
      for (int k = 0; k < NUM_INPUTS; k++) begin
         if ({1'b0, sel} == k[SEL_WIDTH:0]) begin
            sel_data = data_in[k*MUX_BIT_WIDTH +: MUX_BIT_WIDTH];
         end
      end
   end

   assign sel_oor  = ({1'b0, sel} >= c_num_inputs);
   assign accept   = in_valid & in_ready & ~flush;
   assign transfer = main_valid_q & out_ready;

   assign data_out  = main_data_q;
   assign out_valid = main_valid_q;
   assign sel_err   = main_err_q;

`ifdef MUXN_PIPE_SKID_EN

   logic                     skid_valid_q, skid_valid_d;
   logic [MUX_BIT_WIDTH-1:0] skid_data_q, skid_data_d;
   logic                     skid_err_q, skid_err_d;
   logic                     in_ready_q, in_ready_d;

   assign in_ready = in_ready_q;

   // A beat can only be accepted while skid is empty, so skid never
   // needs to load and drain on the same edge.
   always_comb begin
      main_valid_d = main_valid_q;
      main_data_d  = main_data_q;
      main_err_d   = main_err_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      skid_err_d   = skid_err_q;
      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (transfer) begin
         if (skid_valid_q) begin
            main_data_d  = skid_data_q;
            main_err_d   = skid_err_q;
            skid_valid_d = 1'b0;
         end else if (accept) begin
            main_data_d = sel_data;
            main_err_d  = sel_oor;
         end else begin
            main_valid_d = 1'b0;
         end
      end else if (accept) begin
         if (main_valid_q) begin
            skid_valid_d = 1'b1;
            skid_data_d  = sel_data;
            skid_err_d   = sel_oor;
         end else begin
            main_valid_d = 1'b1;
            main_data_d  = sel_data;
            main_err_d   = sel_oor;
         end
      end
      in_ready_d = ~skid_valid_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         main_valid_q <= 1'b0;
         main_data_q  <= '0;
         main_err_q   <= 1'b0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
         skid_err_q   <= 1'b0;
         in_ready_q   <= 1'b1;
      end else begin
         main_valid_q <= main_valid_d;
         main_data_q  <= main_data_d;
         main_err_q   <= main_err_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
         skid_err_q   <= skid_err_d;
         in_ready_q   <= in_ready_d;
      end
   end

`else

   assign in_ready = ~main_valid_q | out_ready;

   always_comb begin
      main_valid_d = main_valid_q;
      main_data_d  = main_data_q;
      main_err_d   = main_err_q;
      if (flush) begin
         main_valid_d = 1'b0;
      end else if (accept) begin
         main_valid_d = 1'b1;
         main_data_d  = sel_data;
         main_err_d   = sel_oor;
      end else if (transfer) begin
         main_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         main_valid_q <= 1'b0;
         main_data_q  <= '0;
         main_err_q   <= 1'b0;
      end else begin
         main_valid_q <= main_valid_d;
         main_data_q  <= main_data_d;
         main_err_q   <= main_err_d;
      end
   end

`endif

endmodule

`default_nettype wire
